// File: rtl/arbiter_pkg.sv
// Shared types and width helpers for the priority round-robin arbiter.
// Widths depend on module parameters, so they are provided as constant functions.
package arbiter_pkg;

    typedef logic [0:0] state_t;

    localparam state_t IDLE  = 1'b0;
    localparam state_t GRANT = 1'b1;

    // ceil(log2(v)) but never less than one bit
    function automatic int clog2_min1(input int v);
        int r;
        r = $clog2(v);
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int calc_idw(input int n);
        return clog2_min1(n);
    endfunction

    function automatic int calc_hcw(input int max_hold);
        return clog2_min1(max_hold + 1);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: highest priority among candidates, ties
// resolved by the first index strictly after rr_ptr, searching upward modulo N.
module arb_pick
    import arbiter_pkg::*;
#(
    parameter int N   = 4,
    parameter int PW  = 2,
    parameter int IDW = calc_idw(N)
) (
    input  logic [N-1:0]    cand,
    input  logic [N*PW-1:0] prio,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  win,
    output logic            found
);

    logic [PW-1:0] max_p;
    logic [N-1:0]  top_mask;
    int            idx;

    always_comb begin
        max_p = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i] && (prio[i*PW +: PW] > max_p)) begin
                max_p = prio[i*PW +: PW];
            end
        end

        top_mask = '0;
        for (int i = 0; i < N; i++) begin
            top_mask[i] = cand[i] && (prio[i*PW +: PW] == max_p);
        end

        // Rotated first-one search starting just after the last winner
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!found && top_mask[idx]) begin
                win   = IDW'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_rr_arbiter.sv
// N-requester arbiter: programmable priorities, round-robin tie break,
// registered non-preemptive grants and an optional hold limit.
module prio_rr_arbiter
    import arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int PW       = 2,
    parameter int MAX_HOLD = 0,
    localparam int IDW     = calc_idw(N),
    localparam int HCW     = calc_hcw(MAX_HOLD)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*PW-1:0] prio,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [IDW-1:0]  gnt_id,
    output logic            preempt,
    output state_t          dbg_state
);

    localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic           preempt_q, preempt_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [HCW-1:0] hold_q, hold_d;

    logic           owner_req;
    logic           others_req;
    logic           force_rel;
    logic [N-1:0]   cand;
    logic [IDW-1:0] win;
    logic           found;

    assign owner_req  = (state_q == GRANT) && req[gnt_id_q];
    assign others_req = |(req & ~gnt_q);
    assign force_rel  = (MAX_HOLD > 0) && owner_req && (hold_q == HOLD_MAX) && others_req;
    // A dropped owner is already absent from req; only a forced release must mask it
    assign cand       = force_rel ? (req & ~gnt_q) : req;

    arb_pick #(
        .N   (N),
        .PW  (PW),
        .IDW (IDW)
    ) u_pick (
        .cand   (cand),
        .prio   (prio),
        .rr_ptr (rr_ptr_q),
        .win    (win),
        .found  (found)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        preempt_d = 1'b0;
        rr_ptr_d  = rr_ptr_q;
        hold_d    = hold_q;

        if ((state_q == GRANT) && owner_req && !force_rel) begin
            if (hold_q < HOLD_MAX) begin
                hold_d = hold_q + HCW'(1);
            end
        end else if (found) begin
            state_d      = GRANT;
            gnt_d        = '0;
            gnt_d[win]   = 1'b1;
            gnt_id_d     = win;
            rr_ptr_d     = win;
            hold_d       = HCW'(1);
            preempt_d    = force_rel;
        end else begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            hold_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            preempt_q <= 1'b0;
            rr_ptr_q  <= IDW'(N - 1);
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            preempt_q <= preempt_d;
            rr_ptr_q  <= rr_ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = gnt_id_q;
    assign preempt   = preempt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Directed bench for prio_rr_arbiter: one instance without a hold limit and
// one with MAX_HOLD=3; expected grants are queued and checked by a monitor.
module tb_prio_rr_arbiter;
    import arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req0, req1;
    logic [7:0] prio0, prio1;

    logic [3:0] gnt0, gnt1;
    logic       gv0, gv1;
    logic [1:0] id0, id1;
    logic       pre0, pre1;
    state_t     st0, st1;

    int n_checks = 0;
    int n_fail   = 0;

    // entry = {dut_sel, exp_preempt, exp_gnt[3:0]}
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    prio_rr_arbiter #(.N(4), .PW(2), .MAX_HOLD(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .prio(prio0),
        .gnt(gnt0), .gnt_valid(gv0), .gnt_id(id0), .preempt(pre0), .dbg_state(st0)
    );

    prio_rr_arbiter #(.N(4), .PW(2), .MAX_HOLD(3)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .prio(prio1),
        .gnt(gnt1), .gnt_valid(gv1), .gnt_id(id1), .preempt(pre1), .dbg_state(st1)
    );

    function automatic logic [1:0] onehot_id(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic v,
                             input logic [1:0] id, input logic p,
                             input logic [3:0] eg, input logic ep);
        check({tag, ".gnt"}, g, eg);
        check({tag, ".gnt_valid"}, {3'b0, v}, {3'b0, |eg});
        check({tag, ".gnt_id"}, {2'b0, id}, {2'b0, onehot_id(eg)});
        check({tag, ".preempt"}, {3'b0, p}, {3'b0, ep});
    endtask

    // Inputs change on the falling edge; expectation is for the following rising edge
    task automatic drive0(input logic [3:0] r, input logic [7:0] p,
                          input logic [3:0] eg, input logic ep);
        @(negedge clk);
        req0  = r;
        prio0 = p;
        exp_q.push_back({1'b0, ep, eg});
    endtask

    task automatic drive1(input logic [3:0] r, input logic [7:0] p,
                          input logic [3:0] eg, input logic ep);
        @(negedge clk);
        req1  = r;
        prio1 = p;
        exp_q.push_back({1'b1, ep, eg});
    endtask

    // Monitor: sample shortly after each rising edge and compare to the queue head
    initial begin
        logic [5:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e[5] == 1'b0) check_out("dut0", gnt0, gv0, id0, pre0, e[3:0], e[4]);
                else              check_out("dut1", gnt1, gv1, id1, pre1, e[3:0], e[4]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b0;
        req0  = 4'b1111;
        req1  = 4'b0000;
        prio0 = 8'h00;
        prio1 = 8'h00;

        // 1. reset values with requests present
        repeat (2) @(posedge clk);
        #2;
        check_out("reset0", gnt0, gv0, id0, pre0, 4'b0000, 1'b0);
        check_out("reset1", gnt1, gv1, id1, pre1, 4'b0000, 1'b0);
        @(negedge clk);
        req0 = 4'b0000;
        rst  = 1'b1;
        drive0(4'b0100, 8'h00, 4'b0100, 1'b0);
        drive0(4'b0000, 8'h00, 4'b0000, 1'b0);

        // 2. priority {1,0,3,3} for requesters 3..0, round-robin inside prio 3
        drive0(4'b1011, 8'b01_00_11_11, 4'b0001, 1'b0);
        drive0(4'b1010, 8'b01_00_11_11, 4'b0010, 1'b0);
        drive0(4'b1000, 8'b01_00_11_11, 4'b1000, 1'b0);
        drive0(4'b0000, 8'b01_00_11_11, 4'b0000, 1'b0);

        // 3. no preemption by a higher-priority late arrival
        drive0(4'b0001, 8'b11_00_00_00, 4'b0001, 1'b0);
        repeat (3) drive0(4'b1001, 8'b11_00_00_00, 4'b0001, 1'b0);
        drive0(4'b1000, 8'b11_00_00_00, 4'b1000, 1'b0);
        drive0(4'b0000, 8'b11_00_00_00, 4'b0000, 1'b0);

        // 4. round-robin fairness at equal priority
        drive0(4'b1111, 8'h00, 4'b0001, 1'b0);
        drive0(4'b1110, 8'h00, 4'b0010, 1'b0);
        drive0(4'b1101, 8'h00, 4'b0100, 1'b0);
        drive0(4'b1011, 8'h00, 4'b1000, 1'b0);
        drive0(4'b0111, 8'h00, 4'b0001, 1'b0);
        drive0(4'b0000, 8'h00, 4'b0000, 1'b0);

        // 5. hold limit of 3 with a waiting requester, then a lone owner
        drive1(4'b0001, 8'h00, 4'b0001, 1'b0);
        drive1(4'b0011, 8'h00, 4'b0001, 1'b0);
        drive1(4'b0011, 8'h00, 4'b0001, 1'b0);
        drive1(4'b0011, 8'h00, 4'b0010, 1'b1);
        drive1(4'b0011, 8'h00, 4'b0010, 1'b0);
        drive1(4'b0001, 8'h00, 4'b0001, 1'b0);
        repeat (6) drive1(4'b0001, 8'h00, 4'b0001, 1'b0);
        drive1(4'b0000, 8'h00, 4'b0000, 1'b0);

        // 6. asynchronous reset between edges drops the grant at once
        drive0(4'b0100, 8'h00, 4'b0100, 1'b0);
        @(posedge clk);
        #3;
        rst  = 1'b0;
        req0 = 4'b1111;
        #1;
        check_out("async_rst", gnt0, gv0, id0, pre0, 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 4'b0001});
        drive0(4'b0000, 8'h00, 4'b0000, 1'b0);

        // drain with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prio_rr_arbiter.md
Name: prio_rr_arbiter

Overview:
Parametrised N-requester arbiter for a single shared resource, and the next generation of the two-requester Arbiter HLSM. Each requester has a programmable priority level. Grants are registered and non-preemptive while the owner holds its request. Ties at equal priority are broken round-robin. An optional hold limit forces the owner to release so that other waiting requesters are not starved. Sits between N bus masters and one shared slave or port.

Parameters:
N, 4, number of requesters (2..16)
PW, 2, width of each priority field; a larger value means higher priority
MAX_HOLD, 0, maximum consecutive grant cycles before forced release when others wait; 0 disables the limit

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
req  in  N  request vector; bit i = requester i wants the resource
prio  in  N*PW  packed priorities; prio[i*PW +: PW] belongs to requester i
gnt  out  N  one-hot grant vector, registered
gnt_valid  out  1  OR of gnt, registered
gnt_id  out  max(1,$clog2(N))  index of the current owner; 0 when gnt_valid=0
preempt  out  1  one-cycle pulse, registered; high in the cycle after a MAX_HOLD forced handoff

Behaviour:
- Reset (rst=0, asynchronous):
  - gnt=0, gnt_valid=0, gnt_id=0, preempt=0.
  - state=IDLE, rr_ptr=N-1 (so index 0 is first in round-robin order), hold_cnt=0.
  - Reset asserted mid-grant drops gnt immediately, without waiting for a clock edge.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise arbitrate, and at the next edge go to GRANT with gnt = one-hot(winner) and hold_cnt=1.
  - Latency is 1 clock from req sampled high to gnt high.
- Arbitration (combinational, evaluated each cycle):
  - Candidate set = requesting indices, minus the owner when a forced release is in progress.
  - Pick the maximum prio value among candidates.
  - Among candidates at that maximum, pick the first index after rr_ptr, searching upward modulo N.
  - rr_ptr is updated to the winner index on every new grant.
- GRANT, owner req still high, no forced release: keep gnt unchanged.
  - Higher-priority requests arriving during ownership do not preempt.
  - hold_cnt increments and saturates at MAX_HOLD.
- GRANT, owner req low:
  - If another candidate exists, hand off directly at the next edge: new one-hot gnt, no idle gap, hold_cnt=1.
  - If none exists, go to IDLE with gnt=0.
- Forced release (MAX_HOLD>0):
  - Occurs when hold_cnt==MAX_HOLD, owner req=1, and some other req bit is 1.
  - The next edge grants the arbitration winner with the owner excluded; preempt=1 for that cycle; hold_cnt=1.
  - If no other request is pending, the owner keeps the grant and hold_cnt stays saturated.
- prio is sampled only in the arbitration cycle; changes during ownership are ignored.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_id and gnt_valid stay consistent with gnt in every cycle.
  - No combinational path from req to gnt.
- Simultaneous owner-drop and new requests in the same cycle: new requests participate in that cycle's arbitration.
- All-zero prio degenerates to pure round-robin. N=2 with MAX_HOLD=0 reproduces the legacy two-requester behaviour, with direct handoff.

Decomposition:
- Package arbiter_pkg:
  - state typedef (IDLE, GRANT).
  - localparam helpers IDW = max(1,$clog2(N)) and HCW = max(1,$clog2(MAX_HOLD+1)).
- Sub-module arb_pick (purely combinational):
  - Inputs: candidate mask, packed prio, rr_ptr.
  - Outputs: winner index and found flag.
  - Implementation: max-priority mask followed by a rotated first-one search.
- The top level holds the FSM, the registers, the hold counter and the output registers.

Test Plan:
1. Reset: rst=0 with req=4'b1111 → gnt=0, gnt_valid=0, gnt_id=0, preempt=0. Release rst, then req=4'b0100 → gnt=4'b0100 and gnt_id=2 one edge later.
2. Priority: req=4'b1011, prio={2'd1,2'd0,2'd3,2'd3} (requesters 3..0) → gnt=4'b0001. Drop req[0] → next edge gnt=4'b0010 (round-robin at prio 3, no idle cycle). Drop req[1] → gnt=4'b1000.
3. Non-preemption: owner 0 at prio 0; raise req[3] at prio 3 → gnt stays 4'b0001 until req[0]=0, then gnt=4'b1000 next edge.
4. Round-robin fairness: all prio=0, req=4'b1111, each owner drops its req for one cycle after being granted → grant order 0,1,2,3,0.
5. MAX_HOLD=3: req[0] held, req[1] raised at cycle 1 → gnt[0] for exactly 3 cycles, then gnt=4'b0010 with preempt=1 for one cycle. With req[0] alone, gnt[0] is held indefinitely and preempt=0.
6. Async reset mid-grant: gnt=4'b0100, assert rst between edges → gnt=0 immediately. After release with req=4'b1111 and equal prio → gnt=4'b0001.
